// File: rtl/radiant_scaler_reader.sv
// WISHBONE initiator that drains the scaler readback window after each start pulse.
// It streams a tagged header word followed by NUM_WORDS scaler words on a ready/valid port.
module radiant_scaler_reader #(
    parameter int          NUM_WORDS  = 16,
    parameter logic [15:0] BASE_ADDR  = 16'h0800,
    parameter int          TIMEOUT    = 255,
    parameter logic [15:0] HEADER_TAG = 16'h5CA1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        clr_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        busy_o,
    output logic        err_o,
    output logic        overrun_o
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, HDR, REQ, OUT} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [15:0]      seq;
    logic [9:0]       tcnt;
    logic             last_word;
    logic             resp_bad;
    logic             timed_out;
    logic             err_set;
    logic             ovr_set;

    assign last_word = (idx == IDX_W'(NUM_WORDS - 1));
    assign resp_bad  = wb_err_i | wb_rty_i;
    assign timed_out = (tcnt == 10'(TIMEOUT));
    // Ack outranks err/rty, which outrank the timeout; only sampled in REQ.
    assign err_set   = (state == REQ) && !wb_ack_i && (resp_bad || timed_out);
    assign ovr_set   = start_i && (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_i) state_next = HDR;
            HDR:  if (m_tready) state_next = REQ;
            REQ:  if (wb_ack_i || resp_bad || timed_out) state_next = OUT;
            OUT:  if (m_tready) state_next = last_word ? IDLE : REQ;
            default: state_next = IDLE;
        endcase
    end

    // Bus and stream controls decode straight from state, so stb drops the cycle after a response.
    always_comb begin
        wb_cyc_o = (state == REQ);
        wb_stb_o = (state == REQ);
        wb_we_o  = 1'b0;
        wb_dat_o = 32'h0;
        wb_sel_o = 4'hF;
        wb_adr_o = BASE_ADDR + (16'(idx) << 2);
        m_tvalid = (state == HDR) || (state == OUT);
        m_tlast  = (state == OUT) && last_word;
        busy_o   = (state != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq       <= 16'h0;
            idx       <= '0;
            tcnt      <= 10'h0;
            m_tdata   <= 32'h0;
            err_o     <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) m_tdata <= {HEADER_TAG, seq};
                HDR:  if (m_tready) idx <= '0;
                REQ: begin
                    if (wb_ack_i) begin
                        m_tdata <= wb_dat_i;
                    end else if (resp_bad || timed_out) begin
                        m_tdata <= 32'hFFFF_FFFF;
                    end
                end
                OUT: begin
                    if (m_tready) begin
                        if (last_word) begin
                            seq <= seq + 16'd1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Held at zero outside REQ so each visit starts counting from 0; saturates.
            if (state != REQ) begin
                tcnt <= 10'h0;
            end else if (tcnt != 10'h3FF) begin
                tcnt <= tcnt + 10'd1;
            end

            if (err_set) begin
                err_o <= 1'b1;
            end else if (clr_i) begin
                err_o <= 1'b0;
            end

            if (ovr_set) begin
                overrun_o <= 1'b1;
            end else if (clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_radiant_scaler_reader.sv
// Bench for radiant_scaler_reader: behavioural WISHBONE responder, randomized backpressure,
// and a stream scoreboard fed from a word-list model of each readout.
module tb_radiant_scaler_reader;

    localparam int          NW  = 4;
    localparam int          TO  = 8;
    localparam logic [15:0] TAG = 16'h5CA1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clr = 1'b0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [15:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat = 32'h0;
    logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic        busy, err, ovr;

    radiant_scaler_reader #(
        .NUM_WORDS(NW), .BASE_ADDR(16'h0800), .TIMEOUT(TO), .HEADER_TAG(TAG)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_dat_i(wb_dat), .wb_ack_i(wb_ack),
        .wb_err_i(wb_err), .wb_rty_i(wb_rty),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .busy_o(busy), .err_o(err), .overrun_o(ovr)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    logic [15:0] seq_m = 16'h0;
    // Response kind per word, 3 bits each: 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err together.
    logic [11:0] resp_kinds = 12'h0;
    int          resp_lat = 2;
    bit          stall_en = 1'b0;
    bit          stray_en = 1'b0;
    int          visit_k = 0;
    int          viol_mix = 0, viol_stable = 0, viol_resp = 0;

    typedef struct {
        logic [11:0] kinds;
        int          lat;
        bit          stall;
        bit          stray;
        bit          ovr_mid;
        bit          ovr_last;
        bit          exp_err;
        bit          exp_ovr;
    } vec_t;

    function automatic logic [2:0] kind_of(input logic [11:0] kinds, input int k);
        return kinds[k*3 +: 3];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: answers after resp_lat strobed cycles; optional stray responses outside a cycle.
    initial begin
        int scnt;
        int k;
        logic [2:0] kd;
        scnt = 0;
        forever begin
            @(posedge clk);
            #2;
            wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
            if (wb_cyc && wb_stb) begin
                scnt++;
                k  = int'((wb_adr - 16'h0800) >> 2) & 3;
                kd = kind_of(resp_kinds, k);
                wb_dat = $urandom();
                if (scnt == resp_lat) begin
                    wb_dat = 32'h0001_0000 + 32'(k);
                    if (kd == 3'd0 || kd == 3'd4) wb_ack = 1'b1;
                    if (kd == 3'd1 || kd == 3'd4) wb_err = 1'b1;
                    if (kd == 3'd2) wb_rty = 1'b1;
                end
            end else begin
                scnt = 0;
                wb_dat = $urandom();
                if (stray_en && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0: wb_ack = 1'b1;
                        1: wb_err = 1'b1;
                        default: wb_rty = 1'b1;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor and scoreboard, sampling at the falling edge.
    initial begin
        bit p_stall, p_resp, p_stb, p_last_hs, hs;
        logic [31:0] p_data;
        logic p_last;
        int vlen, vk;
        logic [2:0] kd;
        logic [32:0] e;
        p_stall = 0; p_resp = 0; p_stb = 0; p_last_hs = 0; p_data = '0; p_last = 0;
        vlen = 0; vk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_stall = 0; p_resp = 0; p_stb = 0; p_last_hs = 0;
            end else begin
                if (p_last_hs) check("busy_after_tlast", 64'(busy), 64'(0));
                if (p_stall && !(m_tvalid && m_tdata == p_data && m_tlast == p_last)) viol_stable++;
                if (p_resp && wb_stb) viol_resp++;
                if (wb_stb && m_tvalid) viol_mix++;
                if (wb_stb && !p_stb) begin
                    check("wb_adr", 64'(wb_adr), 64'(16'h0800 + 16'(4 * visit_k)));
                    vk = visit_k;
                    visit_k++;
                    vlen = 0;
                end
                if (wb_stb) vlen++;
                if (!wb_stb && p_stb) begin
                    kd = kind_of(resp_kinds, vk & 3);
                    if (kd == 3'd3) check("req_len_timeout", 64'(vlen), 64'(TO + 1));
                    else check("req_len_resp", 64'(vlen), 64'(resp_lat));
                end
                hs = m_tvalid && m_tready;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check("stream_extra_beat", {31'h0, m_tlast, m_tdata}, 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_beat", 64'({m_tlast, m_tdata}), 64'(e));
                    end
                end
                p_last_hs = hs && m_tlast;
                p_stall   = m_tvalid && !m_tready;
                p_data    = m_tdata;
                p_last    = m_tlast;
                p_resp    = wb_stb && (wb_ack || wb_err || wb_rty);
                p_stb     = wb_stb;
            end
        end
    end

    // One readout: queue the expected words, pulse start, optionally poke start while busy.
    task automatic run_readout(input logic [11:0] kinds, input int lat, input bit stall,
                               input bit stray, input bit ovr_mid, input bit ovr_last,
                               output bit m_err);
        bit mid_done;
        int cyc;
        logic [2:0] kd;
        logic [31:0] w;
        resp_kinds = kinds; resp_lat = lat; stall_en = stall; stray_en = stray;
        visit_k = 0;
        m_err = 1'b0;
        exp_q.push_back({1'b0, TAG, seq_m});
        for (int k = 0; k < NW; k++) begin
            kd = kind_of(kinds, k);
            w  = (kd == 3'd0 || kd == 3'd4) ? 32'h0001_0000 + 32'(k) : 32'hFFFF_FFFF;
            if (kd == 3'd1 || kd == 3'd2 || kd == 3'd3) m_err = 1'b1;
            exp_q.push_back({k == NW - 1, w});
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        mid_done = 0;
        cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (ovr_mid && !mid_done && m_tvalid && visit_k > 0 && !m_tlast) begin
                start = 1'b1;
                mid_done = 1;
            end
            if (ovr_last && m_tvalid && m_tlast && m_tready) start = 1'b1;
        end
        start = 1'b0;
        if (cyc >= 3000) check("readout_timeout", 64'(1), 64'(0));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        seq_m = seq_m + 16'd1;
        stray_en = 1'b0;
    endtask

    task automatic clear_flags();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("err_after_clr", 64'(err), 64'(0));
        check("ovr_after_clr", 64'(ovr), 64'(0));
    endtask

    initial begin
        vec_t vecs[7];
        bit   m_err;
        int   cyc;
        logic [11:0] kinds;
        int   r;

        vecs[0] = '{12'h000, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // clean, 2-cycle ack
        vecs[1] = '{12'h000, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // backpressure
        vecs[2] = '{12'h0C0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // word 2 times out
        vecs[3] = '{12'h011, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // err then rty
        vecs[4] = '{12'h000, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // start while busy
        vecs[5] = '{12'h020, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // ack ties err and timeout
        vecs[6] = '{12'h000, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // stray responses ignored

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", 64'(wb_cyc), 64'(0));
        check("rst_stb", 64'(wb_stb), 64'(0));
        check("rst_adr", 64'(wb_adr), 64'(16'h0800));
        check("rst_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_tlast", 64'(m_tlast), 64'(0));
        check("rst_tdata", 64'(m_tdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_ovr", 64'(ovr), 64'(0));
        check("const_we", 64'(wb_we), 64'(0));
        check("const_sel", 64'(wb_sel), 64'(4'hF));
        check("const_dat", 64'(wb_dat_o), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_readout(vecs[i].kinds, vecs[i].lat, vecs[i].stall, vecs[i].stray,
                        vecs[i].ovr_mid, vecs[i].ovr_last, m_err);
            check("row_err", 64'(err), 64'(vecs[i].exp_err));
            check("row_ovr", 64'(ovr), 64'(vecs[i].exp_ovr));
            clear_flags();
        end

        for (int i = 0; i < 16; i++) begin
            kinds = 12'h0;
            for (int k = 0; k < NW; k++) begin
                r = $urandom_range(0, 9);
                kinds[k*3 +: 3] = (r < 6) ? 3'd0 : 3'(r - 5);
            end
            run_readout(kinds, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b0, 1'b0, m_err);
            check("rand_err", 64'(err), 64'(m_err));
            check("rand_ovr", 64'(ovr), 64'(0));
            clear_flags();
        end

        // Reset while a silent responder holds the FSM in REQ.
        resp_kinds = 12'h6DB; resp_lat = 2; stall_en = 1'b0; visit_k = 0;
        exp_q.push_back({1'b0, TAG, seq_m});
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (!wb_stb && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_req", 64'(wb_stb), 64'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_cyc", 64'(wb_cyc), 64'(0));
        check("mid_rst_stb", 64'(wb_stb), 64'(0));
        check("mid_rst_tvalid", 64'(m_tvalid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_queue", 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        seq_m = 16'h0;
        run_readout(12'h000, 2, 1'b0, 1'b0, 1'b0, 1'b0, m_err);
        check("post_rst_err", 64'(err), 64'(0));
        check("post_rst_ovr", 64'(ovr), 64'(0));

        check("stb_while_tvalid", 64'(viol_mix), 64'(0));
        check("tdata_stable_in_stall", 64'(viol_stable), 64'(0));
        check("stb_after_response", 64'(viol_resp), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radiant_scaler_reader.md
Name: radiant_scaler_reader

Overview:
- WISHBONE initiator that drains the scaler readback window word by word.
- On each start pulse (scaler update done, or a software request) it emits a header word, then reads NUM_WORDS consecutive 32-bit scaler words.
- It pushes the header and all read words out on a ready/valid stream for event formatting.
- It sits between the scaler responder's WISHBONE port and the event/housekeeping packer, all in the 50 MHz domain.

Parameters:
NUM_WORDS, 16, dual-scaler words read per readout (1..64).
BASE_ADDR, 16'h0800, byte address of first scaler word; stride 4.
TIMEOUT, 255, cycles to wait for ack before aborting a read (1..1023).
HEADER_TAG, 16'h5CA1, upper 16 bits of header word.

Ports:
clk_i  in  1  system clock (50 MHz).
rst_i  in  1  synchronous active-high reset.
start_i  in  1  single-cycle readout request.
clr_i  in  1  clears sticky err_o/overrun_o.
wb_cyc_o  out  1  WISHBONE cycle.
wb_stb_o  out  1  WISHBONE strobe.
wb_we_o  out  1  always 0 (reads only).
wb_adr_o  out  16  byte address.
wb_dat_o  out  32  always 0.
wb_sel_o  out  4  always 4'hF.
wb_dat_i  in  32  read data.
wb_ack_i  in  1  transfer ack.
wb_err_i  in  1  transfer error.
wb_rty_i  in  1  retry (treated as error).
m_tdata  out  32  stream data.
m_tvalid  out  1  stream valid.
m_tlast  out  1  last word of readout.
m_tready  in  1  stream ready.
busy_o  out  1  readout in progress.
err_o  out  1  sticky: any err/rty/timeout.
overrun_o  out  1  sticky: start_i while busy.

Behaviour:
- Clocking and reset: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: state IDLE; wb_cyc_o=wb_stb_o=0; wb_adr_o=BASE_ADDR; m_tvalid=0; m_tlast=0; m_tdata=0; busy_o=0; err_o=0; overrun_o=0; seq=0; idx=0.
- FSM states:
  - IDLE: start_i latches current seq into header and moves to HDR.
  - HDR: m_tdata={HEADER_TAG,seq[15:0]}, m_tvalid=1, m_tlast=0. On m_tready moves to REQ with idx=0.
  - REQ: wb_cyc_o=wb_stb_o=1, wb_adr_o=BASE_ADDR+4*idx. The timeout counter clears on entry.
    - On a cycle with wb_ack_i=1: capture wb_dat_i into m_tdata, go to OUT.
    - On wb_err_i or wb_rty_i: capture 32'hFFFFFFFF, set err_o, go to OUT.
    - On counter==TIMEOUT with no response: same as error.
    - Precedence: ack > err/rty > timeout.
  - OUT: m_tvalid=1, m_tlast=(idx==NUM_WORDS-1). On m_tready:
    - if last: seq<=seq+1 (wraps 16'hFFFF->0), go to IDLE;
    - else idx<=idx+1, go to REQ.
- WISHBONE strobe timing:
  - cyc/stb are decoded from state, so they deassert the cycle after ack is sampled.
  - The responder's one-cycle ACK state must never see stb high on its following IDLE cycle. Exactly one transfer per REQ visit.
  - Response signals arriving outside REQ are ignored.
- busy_o=1 in every state except IDLE.
- Latency: with zero-wait responder acking 2 cycles after stb and m_tready held high, the readout occupies 1 (HDR) + NUM_WORDS*(ack latency+1) cycles, and busy_o falls the cycle after the tlast handshake.
- Stream rules:
  - m_tdata/m_tlast are stable while m_tvalid=1 and m_tready=0.
  - Backpressure holds the FSM in HDR/OUT indefinitely; no WISHBONE access occurs while a word is pending.
- start_i handling:
  - start_i in any non-IDLE state is dropped and sets overrun_o.
  - start_i on the same cycle the FSM returns to IDLE is also dropped (overrun).
- Sticky flags: clr_i clears err_o/overrun_o. A simultaneous set event wins over clr_i.
- Reset mid-readout: cyc/stb and m_tvalid drop the next cycle; seq returns to 0; no partial tlast is emitted.
- Counter widths: idx is $clog2(NUM_WORDS) bits, min 1 bit. The timeout counter is 10 bits and saturates.

Test Plan:
1. NUM_WORDS=4, responder acks 2 cycles after stb with data 0x00010000+idx, tready=1, start pulse -> stream 0x5CA10000, 0x00010000..0x00010003 at adr 0x0800/0804/0808/080C; tlast only on 4th word; stb low the cycle after each ack; busy_o falls after the last handshake.
2. Same, tready toggled 1-0-0-1 pseudo-randomly -> identical word sequence; no stb while m_tvalid=1; tdata stable during stalls; second start gives header 0x5CA10001.
3. Responder never acks word 2, TIMEOUT=8 -> word 2 = 0xFFFFFFFF exactly 8 cycles after entering REQ; err_o=1; words 3..N still read; clr_i clears err_o.
4. wb_err_i on word 0, wb_rty_i on word 1 -> both words 0xFFFFFFFF, err_o=1, readout completes with tlast.
5. start_i pulsed during OUT and on the tlast handshake cycle -> both ignored, overrun_o=1, exactly one readout emitted.
6. rst_i asserted mid-REQ -> next cycle cyc/stb/tvalid=0, busy_o=0; subsequent start yields header 0x5CA10000 and a full clean readout.
